pkt_tx_gen: RTL and testbench



---
 rtl/pkt_tx_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_pkt_tx_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_gen.sv
`default_nettype none
// ============================================================================
// Module   : pkt_tx_gen
// Purpose  : Packet generator driving the xge_mac POS-L3 pkt_tx_* interface
//            with incrementing, constant or LFSR payloads and a programmable gap.
// Revision : 1.0  initial release
// ============================================================================
module pkt_tx_gen #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16,
    parameter int MOD_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  pkt_len,
    input  logic [CNT_W-1:0]  pkt_count,
    input  logic [7:0]        ipg_cycles,
    input  logic [1:0]        mode,
    input  logic [7:0]        seed,
    input  logic              pkt_tx_full,
    output logic [DATA_W-1:0] pkt_tx_data,
    output logic              pkt_tx_val,
    output logic              pkt_tx_sop,
    output logic              pkt_tx_eop,
    output logic [MOD_W-1:0]  pkt_tx_mod,
    output logic              busy,
    output logic [CNT_W-1:0]  pkts_sent
);

    localparam int         BYTES     = DATA_W / 8;
    localparam int         VC_W      = $clog2(BYTES + 1);
    localparam logic [7:0] BYTES_MOD = 8'(BYTES % 256);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic [MOD_W-1:0]  len_mod_q, len_mod_d;
    logic [VC_W-1:0]   last_cnt_q, last_cnt_d;
    logic [7:0]        ipg_q, ipg_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        seed_q, seed_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [7:0]        byte_base_q, byte_base_d;
    logic              stop_seen_q, stop_seen_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_val_q, tx_val_d;
    logic              tx_sop_q, tx_sop_d;
    logic              tx_eop_q, tx_eop_d;
    logic [MOD_W-1:0]  tx_mod_q, tx_mod_d;
    logic              busy_q, busy_d;

    logic              start_ok;
    logic              emit;
    logic              is_last;
    logic              pkt_done;
    logic              stop_any;
    logic              finish;
    logic [CNT_W-1:0]  sent_inc;
    logic [VC_W-1:0]   valid_cnt;
    logic [CNT_W:0]    len_round;
    logic [CNT_W-1:0]  len_rem;
    logic [DATA_W-1:0] word_data;
    logic [7:0]        lfsr_chain [0:BYTES];

    assign start_ok  = start && (pkt_len != '0);
    assign emit      = (state_q == ST_SEND) && !pkt_tx_full;
    assign is_last   = (word_idx_q == words_q - CNT_W'(1));
    assign pkt_done  = emit && is_last;
    assign stop_any  = stop_seen_q || stop;
    assign sent_inc  = sent_q + CNT_W'(1);
    assign finish    = ((count_q != '0) && (sent_inc == count_q)) || stop_any;
    assign valid_cnt = is_last ? last_cnt_q : VC_W'(BYTES);
    assign len_round = {1'b0, pkt_len} + (CNT_W+1)'(BYTES - 1);
    assign len_rem   = pkt_len % CNT_W'(BYTES);

    // Byte lanes: lane j carries packet byte (word_idx*BYTES + j); padding lanes are zero
    assign lfsr_chain[0] = lfsr_q;
    for (genvar j = 0; j < BYTES; j++) begin : g_lane
        logic [7:0] lane_byte;
        assign lfsr_chain[j+1] = lfsr_step(lfsr_chain[j]);
        always_comb begin
            case (mode_q)
                2'd1:    lane_byte = seed_q;
                2'd2:    lane_byte = lfsr_chain[j];
                default: lane_byte = seed_q + byte_base_q + 8'(j);
            endcase
        end
        assign word_data[DATA_W-1-8*j -: 8] = (VC_W'(j) < valid_cnt) ? lane_byte : 8'h00;
    end

    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            words_q     <= '0;
            word_idx_q  <= '0;
            sent_q      <= '0;
            len_mod_q   <= '0;
            last_cnt_q  <= '0;
            ipg_q       <= '0;
            gap_cnt_q   <= '0;
            mode_q      <= '0;
            seed_q      <= '0;
            lfsr_q      <= 8'h01;
            byte_base_q <= '0;
            stop_seen_q <= 1'b0;
            tx_data_q   <= '0;
            tx_val_q    <= 1'b0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            tx_mod_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            words_q     <= words_d;
            word_idx_q  <= word_idx_d;
            sent_q      <= sent_d;
            len_mod_q   <= len_mod_d;
            last_cnt_q  <= last_cnt_d;
            ipg_q       <= ipg_d;
            gap_cnt_q   <= gap_cnt_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            lfsr_q      <= lfsr_d;
            byte_base_q <= byte_base_d;
            stop_seen_q <= stop_seen_d;
            tx_data_q   <= tx_data_d;
            tx_val_q    <= tx_val_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
            tx_mod_q    <= tx_mod_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_SEND;
            ST_SEND: begin
                if (pkt_done) begin
                    if (finish)                state_d = ST_IDLE;
                    else if (ipg_q == 8'd0)    state_d = ST_SEND;
                    else                       state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 8'd1) state_d = stop_any ? ST_IDLE : ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        words_d     = words_q;
        word_idx_d  = word_idx_q;
        sent_d      = sent_q;
        len_mod_d   = len_mod_q;
        last_cnt_d  = last_cnt_q;
        ipg_d       = ipg_q;
        gap_cnt_d   = gap_cnt_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        lfsr_d      = lfsr_q;
        byte_base_d = byte_base_q;
        stop_seen_d = (state_q == ST_IDLE) ? 1'b0 : stop_any;
        tx_data_d   = '0;
        tx_val_d    = 1'b0;
        tx_sop_d    = 1'b0;
        tx_eop_d    = 1'b0;
        tx_mod_d    = '0;
        busy_d      = (state_d != ST_IDLE);

        if (state_q == ST_IDLE && start_ok) begin
            count_d     = pkt_count;
            words_d     = CNT_W'(len_round / (CNT_W+1)'(BYTES));
            len_mod_d   = MOD_W'(len_rem);
            last_cnt_d  = (len_rem == '0) ? VC_W'(BYTES) : VC_W'(len_rem);
            ipg_d       = ipg_cycles;
            mode_d      = mode;
            seed_d      = seed;
            lfsr_d      = (seed == 8'h00) ? 8'h01 : seed;
            word_idx_d  = '0;
            byte_base_d = '0;
            sent_d      = '0;
        end

        if (emit) begin
            tx_data_d   = word_data;
            tx_val_d    = 1'b1;
            tx_sop_d    = (word_idx_q == '0);
            tx_eop_d    = is_last;
            tx_mod_d    = is_last ? len_mod_q : '0;
            lfsr_d      = lfsr_chain[valid_cnt];
            word_idx_d  = word_idx_q + CNT_W'(1);
            byte_base_d = byte_base_q + BYTES_MOD;
            if (is_last) begin
                sent_d      = sent_inc;
                word_idx_d  = '0;
                byte_base_d = '0;
                gap_cnt_d   = ipg_q;
            end
        end

        if (state_q == ST_GAP) gap_cnt_d = gap_cnt_q - 8'd1;
    end

    assign pkt_tx_data = tx_data_q;
    assign pkt_tx_val  = tx_val_q;
    assign pkt_tx_sop  = tx_sop_q;
    assign pkt_tx_eop  = tx_eop_q;
    assign pkt_tx_mod  = tx_mod_q;
    assign busy        = busy_q;
    assign pkts_sent   = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_tx_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_tx_gen
// Purpose  : Directed self-checking bench for pkt_tx_gen (64- and 128-bit).
// Revision : 1.0  initial release
// ============================================================================
module tb_pkt_tx_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, stop, full;
    logic [15:0] len, count;
    logic [7:0]  ipg, seed;
    logic [1:0]  mode;

    logic [63:0]  data_a;
    logic         val_a, sop_a, eop_a, busy_a;
    logic [2:0]   mod_a;
    logic [15:0]  sent_a;
    logic [127:0] data_b;
    logic         val_b, sop_b, eop_b, busy_b;
    logic [3:0]   mod_b;
    logic [15:0]  sent_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pkt_tx_gen #(.DATA_W(64)) dut_a (
        .clk_156m25(clk), .reset_156m25_n(rst_n), .start(start_a), .stop(stop),
        .pkt_len(len), .pkt_count(count), .ipg_cycles(ipg), .mode(mode), .seed(seed),
        .pkt_tx_full(full), .pkt_tx_data(data_a), .pkt_tx_val(val_a), .pkt_tx_sop(sop_a),
        .pkt_tx_eop(eop_a), .pkt_tx_mod(mod_a), .busy(busy_a), .pkts_sent(sent_a)
    );

    pkt_tx_gen #(.DATA_W(128)) dut_b (
        .clk_156m25(clk), .reset_156m25_n(rst_n), .start(start_b), .stop(stop),
        .pkt_len(len), .pkt_count(count), .ipg_cycles(ipg), .mode(mode), .seed(seed),
        .pkt_tx_full(full), .pkt_tx_data(data_b), .pkt_tx_val(val_b), .pkt_tx_sop(sop_b),
        .pkt_tx_eop(eop_b), .pkt_tx_mod(mod_b), .busy(busy_b), .pkts_sent(sent_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic [7:0]  lseq [0:23];
    logic [63:0] exp_w;
    logic [7:0]  s;
    int          nwords;
    logic        exp_val;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; stop = 1'b0; full = 1'b0;
        len = '0; count = '0; ipg = '0; seed = '0; mode = '0;
        repeat (3) tick();
        chk("rst_val", val_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_sent", sent_a, 0);
        chk("rst_data", data_a, 0);
        rst_n = 1'b1;

        // 13-byte incrementing packet
        len = 16'd13; count = 16'd1; ipg = 8'd0; mode = 2'd0; seed = 8'h10;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t1_busy_up", busy_a, 1);
        chk("t1_val_lat", val_a, 0);
        tick();
        chk("t1_w0_data", data_a, 64'h1011121314151617);
        chk("t1_w0_sop", {val_a, sop_a, eop_a, mod_a}, {1'b1, 1'b1, 1'b0, 3'd0});
        tick();
        chk("t1_w1_data", data_a, 64'h18191A1B1C000000);
        chk("t1_w1_eop", {val_a, sop_a, eop_a, mod_a}, {1'b1, 1'b0, 1'b1, 3'd5});
        chk("t1_sent", sent_a, 1);
        chk("t1_busy_dn", busy_a, 0);
        tick();
        chk("t1_idle_val", val_a, 0);

        // three single-word packets back to back
        len = 16'd8; count = 16'd3; ipg = 8'd0; seed = 8'h00;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk("t2_b2b_flags", {val_a, sop_a, eop_a, mod_a}, {1'b1, 1'b1, 1'b1, 3'd0});
            chk("t2_b2b_data", data_a, 64'h0001020304050607);
        end
        chk("t2_b2b_sent", sent_a, 3);
        chk("t2_b2b_busy", busy_a, 0);

        // ipg = 2 between two single-word packets
        count = 16'd2; ipg = 8'd2;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        chk("t2_ipg_p0", {val_a, sop_a, eop_a}, 3'b111);
        tick();
        chk("t2_ipg_gap0", val_a, 0);
        tick();
        chk("t2_ipg_gap1", val_a, 0);
        tick();
        chk("t2_ipg_p1", {val_a, sop_a, eop_a}, 3'b111);
        chk("t2_ipg_sent", sent_a, 2);
        chk("t2_ipg_busy", busy_a, 0);

        // back-pressure: full high for 4 edges mid-packet
        len = 16'd64; count = 16'd1; ipg = 8'd0; mode = 2'd1; seed = 8'hA5;
        start_a = 1'b1; tick(); start_a = 1'b0;
        nwords = 0;
        for (int i = 0; i < 13; i++) begin
            full = (i >= 2 && i <= 5);
            tick();
            exp_val = (i <= 11) && !(i >= 2 && i <= 5);
            chk("t3_val", val_a, exp_val);
            if (val_a) begin
                nwords++;
                chk("t3_data", data_a, 64'hA5A5A5A5A5A5A5A5);
            end
            if (i == 11) chk("t3_eop", {eop_a, sop_a, mod_a}, {1'b1, 1'b0, 3'd0});
        end
        full = 1'b0;
        chk("t3_nwords", nwords, 8);
        chk("t3_busy", busy_a, 0);

        // LFSR with seed 0, 12-byte packets, continuing across the packet boundary
        s = 8'h01;
        for (int k = 0; k < 24; k++) begin
            lseq[k] = s;
            s = lstep(s);
        end
        len = 16'd12; count = 16'd2; ipg = 8'd0; mode = 2'd2; seed = 8'h00;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int w = 0; w < 2; w++) begin
                tick();
                exp_w = '0;
                for (int j = 0; j < 8; j++)
                    if (w == 0 || j < 4) exp_w[63-8*j -: 8] = lseq[p*12 + w*8 + j];
                chk("t4_lfsr_data", data_a, exp_w);
                chk("t4_lfsr_flags", {val_a, sop_a, eop_a, mod_a},
                    {1'b1, (w == 0), (w == 1), (w == 1) ? 3'd4 : 3'd0});
                if (p == 0 && w == 0) chk("t4_first_byte", data_a[63:56], 8'h01);
            end
        end

        // 128-bit instance: 17 bytes -> 2 words, mod 1
        len = 16'd17; count = 16'd1; mode = 2'd0; seed = 8'h20;
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick();
        chk("t4_w128_d0", data_b, 128'h202122232425262728292A2B2C2D2E2F);
        chk("t4_w128_f0", {val_b, sop_b, eop_b}, 3'b110);
        tick();
        chk("t4_w128_d1", data_b, 128'h30000000000000000000000000000000);
        chk("t4_w128_f1", {val_b, sop_b, eop_b, mod_b}, {1'b1, 1'b0, 1'b1, 4'd1});
        chk("t4_w128_busy", busy_b, 0);

        // continuous mode with stop mid-packet
        len = 16'd24; count = 16'd0; ipg = 8'd1; mode = 2'd1; seed = 8'h3C;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(); tick(); tick();
        chk("t5_p0_eop", {val_a, eop_a, busy_a}, 3'b111);
        chk("t5_p0_sent", sent_a, 1);
        tick();
        chk("t5_gap", val_a, 0);
        tick();
        chk("t5_p1_sop", {val_a, sop_a}, 2'b11);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t5_p1_mid", {val_a, eop_a, busy_a}, 3'b101);
        tick();
        chk("t5_p1_eop", {val_a, eop_a, busy_a}, 3'b110);
        chk("t5_sent", sent_a, 2);
        tick();
        chk("t5_idle", {val_a, busy_a}, 2'b00);
        len = 16'd8; count = 16'd1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t5_restart_clr", sent_a, 0);
        tick();
        chk("t5_restart_pkt", {val_a, eop_a}, 2'b11);
        chk("t5_restart_sent", sent_a, 1);

        // reset mid-packet, then zero-length start
        len = 16'd24; count = 16'd1; mode = 2'd0; seed = 8'h00;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        chk("t6_pre_rst", val_a, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t6_rst_flags", {val_a, sop_a, eop_a, busy_a}, 4'b0000);
        chk("t6_rst_sent", sent_a, 0);
        len = 16'd0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t6_zero_len_busy", busy_a, 0);
        tick();
        chk("t6_zero_len_val", {val_a, busy_a}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
